// File: rtl/gate_truth_checker.sv
// Sweeps every input vector of a small combinational gate, samples its output after a settle
// delay and tallies mismatches against a truth-table constant.
module gate_truth_checker #(
   parameter int unsigned          N_IN   = 2,
   parameter logic [2**N_IN-1:0]   TRUTH  = 4'b1110,
   parameter int unsigned          SETTLE = 4,
   parameter int unsigned          CNT_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic [N_IN-1:0]   o_dut_vec,
   input  logic              i_dut_y,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [CNT_W-1:0]  o_err_count,
   output logic              o_fail_valid,
   output logic [N_IN-1:0]   o_fail_vec
);

   // Wide enough to hold SETTLE itself, so the final WAIT increment never wraps.
   localparam int unsigned    SW          = $clog2(SETTLE + 1);
   localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [N_IN-1:0] VEC_LAST   = {N_IN{1'b1}};

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StWait   = 2'd1;
   localparam logic [1:0] StSample = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   logic [1:0]       r_state;
   logic [SW-1:0]    r_cnt;
   logic [N_IN-1:0]  r_vec;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [CNT_W-1:0] r_err;
   logic             r_fail_valid;
   logic [N_IN-1:0]  r_fail_vec;

   logic w_expect;
   logic w_mismatch;
   logic w_err_sat;

   assign w_expect   = TRUTH[r_vec];
   assign w_mismatch = (i_dut_y != w_expect);
   assign w_err_sat  = &r_err;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_cnt        <= '0;
         r_vec        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err        <= '0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
      end else begin
         case (r_state)
            StIdle, StDone: begin
               if (i_start) begin
                  r_vec        <= '0;
                  r_err        <= '0;
                  r_fail_valid <= 1'b0;
                  r_fail_vec   <= '0;
                  r_cnt        <= '0;
                  r_done       <= 1'b0;
                  r_pass       <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= StWait;
               end
            end
            StWait: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == SETTLE_LAST) begin
                  r_state <= StSample;
               end
            end
            StSample: begin
               if (w_mismatch) begin
                  if (!w_err_sat) begin
                     r_err <= r_err + 1'b1;
                  end
                  if (!r_fail_valid) begin
                     r_fail_valid <= 1'b1;
                     r_fail_vec   <= r_vec;
                  end
               end
               if (r_vec == VEC_LAST) begin
                  r_state <= StDone;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  // Pass reflects the final tally, including this last sample.
                  r_pass  <= (r_err == '0) && !w_mismatch;
               end else begin
                  r_vec   <= r_vec + 1'b1;
                  r_cnt   <= '0;
                  r_state <= StWait;
               end
            end
         endcase
      end
   end

   assign o_dut_vec    = r_vec;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_err_count  = r_err;
   assign o_fail_valid = r_fail_valid;
   assign o_fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: the driver queues the expected sweep result, a monitor checks each done.
module tb_gate_truth_checker;

   typedef struct {
      int err;
      int fv;
      int fvec;
      int pass;
      int cycles;
   } exp_t;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: defaults (2-input OR truth table, SETTLE=4)
   logic       rst_a = 1'b1, start_a = 1'b0, y_a;
   logic [1:0] vec_a, fvec_a;
   logic [7:0] err_a;
   logic       busy_a, done_a, pass_a, fv_a;
   int         mode_a = 0;

   // Instance B: saturation configuration
   logic       rst_b = 1'b1, start_b = 1'b0, y_b;
   logic [2:0] vec_b, fvec_b;
   logic [1:0] err_b;
   logic       busy_b, done_b, pass_b, fv_b;

   always_comb begin
      y_a = 1'b0;
      case (mode_a)
         0: y_a = |vec_a;
         1: y_a = &vec_a;
         default: y_a = 1'b0;
      endcase
   end
   assign y_b = 1'b1;

   gate_truth_checker u_dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .o_dut_vec(vec_a), .i_dut_y(y_a),
      .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a), .o_err_count(err_a),
      .o_fail_valid(fv_a), .o_fail_vec(fvec_a)
   );

   gate_truth_checker #(.N_IN(3), .TRUTH(8'h80), .SETTLE(1), .CNT_W(2)) u_dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .o_dut_vec(vec_b), .i_dut_y(y_b),
      .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b), .o_err_count(err_b),
      .o_fail_valid(fv_b), .o_fail_vec(fvec_b)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t q0[$];
   exp_t q1[$];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor view of both instances
   int m_busy[2], m_done[2], m_vec[2], m_err[2], m_fv[2], m_fvec[2], m_pass[2];
   always_comb begin
      m_busy[0] = int'(busy_a); m_done[0] = int'(done_a); m_vec[0]  = int'(vec_a);
      m_err[0]  = int'(err_a);  m_fv[0]   = int'(fv_a);   m_fvec[0] = int'(fvec_a);
      m_pass[0] = int'(pass_a);
      m_busy[1] = int'(busy_b); m_done[1] = int'(done_b); m_vec[1]  = int'(vec_b);
      m_err[1]  = int'(err_b);  m_fv[1]   = int'(fv_b);   m_fvec[1] = int'(fvec_b);
      m_pass[1] = int'(pass_b);
   end

   initial begin : monitor
      int   per_vec[2];
      int   bcnt[2];
      int   vbad[2];
      int   bprev[2];
      int   dprev[2];
      int   have;
      exp_t e;
      per_vec[0] = 5; per_vec[1] = 2;
      for (int i = 0; i < 2; i++) begin
         bcnt[i] = 0; vbad[i] = 0; bprev[i] = 0; dprev[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (m_busy[i] != 0 && bprev[i] == 0) begin
               bcnt[i] = 0;
               vbad[i] = 0;
            end
            if (m_busy[i] != 0) begin
               if (m_vec[i] != bcnt[i] / per_vec[i]) vbad[i] = 1;
               bcnt[i]++;
            end
            if (m_done[i] != 0 && dprev[i] == 0) begin
               have = (i == 0) ? q0.size() : q1.size();
               if (have == 0) begin
                  check($sformatf("unexpected_done%0d", i), 1, 0);
               end else begin
                  e = (i == 0) ? q0.pop_front() : q1.pop_front();
                  check($sformatf("err_count%0d", i), m_err[i], e.err);
                  check($sformatf("fail_valid%0d", i), m_fv[i], e.fv);
                  check($sformatf("fail_vec%0d", i), m_fvec[i], e.fvec);
                  check($sformatf("pass%0d", i), m_pass[i], e.pass);
                  check($sformatf("sweep_cycles%0d", i), bcnt[i], e.cycles);
                  check($sformatf("vec_sequence%0d", i), vbad[i], 0);
                  check($sformatf("busy_low_at_done%0d", i), m_busy[i], 0);
               end
            end
            bprev[i] = m_busy[i];
            dprev[i] = m_done[i];
         end
      end
   end

   task automatic expect_a(input int err, input int fv, input int fvec, input int pass);
      exp_t e;
      e.err = err; e.fv = fv; e.fvec = fvec; e.pass = pass; e.cycles = 20;
      q0.push_back(e);
   endtask

   task automatic pulse_start_a();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
   endtask

   task automatic wait_done(input int i);
      int n = 0;
      while (((i == 0) ? done_a : done_b) !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("done_timeout%0d", i), n < 200 ? 1 : 0, 1);
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_vec"},  int'(vec_a), 0);
      check({tag, "_busy"}, int'(busy_a), 0);
      check({tag, "_done"}, int'(done_a), 0);
      check({tag, "_pass"}, int'(pass_a), 0);
      check({tag, "_err"},  int'(err_a), 0);
      check({tag, "_fv"},   int'(fv_a), 0);
      check({tag, "_fvec"}, int'(fvec_a), 0);
   endtask

   initial begin : stimulus
      exp_t eb;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      check_reset_a("reset");

      // 1: correct OR gate
      mode_a = 0;
      expect_a(0, 0, 0, 1);
      pulse_start_a();
      wait_done(0);

      // 2: AND wired in place of OR, vectors 1 and 2 mismatch
      mode_a = 1;
      expect_a(2, 1, 1, 0);
      pulse_start_a();
      wait_done(0);

      // 3: stuck-at-0, then a correct OR clears everything
      mode_a = 2;
      expect_a(3, 1, 1, 0);
      pulse_start_a();
      wait_done(0);
      mode_a = 0;
      expect_a(0, 0, 0, 1);
      pulse_start_a();
      wait_done(0);

      // 4: reset mid-sweep, then a clean full sweep
      mode_a = 1;
      pulse_start_a();
      repeat (6) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      check_reset_a("abort");
      mode_a = 0;
      expect_a(0, 0, 0, 1);
      pulse_start_a();
      wait_done(0);

      // 5: start pulses during a sweep are ignored
      expect_a(0, 0, 0, 1);
      pulse_start_a();
      repeat (2) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      repeat (6) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      wait_done(0);

      // Start held high in DONE relaunches; done drops on the next cycle
      mode_a = 1;
      expect_a(2, 1, 1, 0);
      start_a = 1'b1;
      @(negedge clk);
      check("restart_done_low", int'(done_a), 0);
      check("restart_busy_high", int'(busy_a), 1);
      repeat (2) @(negedge clk);
      start_a = 1'b0;
      wait_done(0);

      // 6: saturating 2-bit counter, 16-cycle sweep
      eb.err = 3; eb.fv = 1; eb.fvec = 0; eb.pass = 0; eb.cycles = 16;
      q1.push_back(eb);
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      wait_done(1);

      repeat (3) @(negedge clk);
      check("queue_empty", q0.size() + q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
